// File: rtl/skew_shape_tx_if.sv
// Interface for skew_shape_tx: bundles the activation-buffer side
// (in_data, in_data_vld, in_data_last, in_data_rdy), the systolic-array
// row side (out_data, out_data_vld, out_data_rdy) and the per-bank tile
// status (busy, done).
//   master : the environment (activation buffer + array rows + controller)
//   slave  : the skew shaper itself
interface skew_shape_tx_if #(
  parameter int ACT_WIDTH = 8,
  parameter int NUM_BANK  = 4,
  parameter int NUM_ROW   = 16
);
  logic [NUM_BANK*NUM_ROW*ACT_WIDTH-1:0] in_data;
  logic [NUM_BANK-1:0]                   in_data_vld;
  logic [NUM_BANK-1:0]                   in_data_last;
  logic [NUM_BANK-1:0]                   in_data_rdy;
  logic [NUM_BANK*NUM_ROW*ACT_WIDTH-1:0] out_data;
  logic [NUM_BANK*NUM_ROW-1:0]           out_data_vld;
  logic [NUM_BANK*NUM_ROW-1:0]           out_data_rdy;
  logic [NUM_BANK-1:0]                   busy;
  logic [NUM_BANK-1:0]                   done;

  modport master (
    output in_data, in_data_vld, in_data_last, out_data_rdy,
    input  in_data_rdy, out_data, out_data_vld, busy, done
  );

  modport slave (
    input  in_data, in_data_vld, in_data_last, out_data_rdy,
    output in_data_rdy, out_data, out_data_vld, busy, done
  );
endinterface

// File: rtl/skew_shape_tx.sv
// skew_shape_tx: diagonal skew shaper feeding systolic-array rows.
// Each bank accepts one packed word (NUM_ROW activations) per cycle and
// delivers activation j to row j through a j+1 deep register line, so row j
// sees the word j cycles after row 0. A bank advances as a whole only when
// every valid row of that bank is being consumed. Tile framing tracks the
// last word and pulses done once the bank's skew lines are empty.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   cfg_bypass  (only with SKEW_SHAPE_BYPASS_EN) drop the skew for a tile
//   bus         skew_shape_tx_if.slave: in_data/vld/last/rdy,
//               out_data/vld/rdy, busy, done
// Optional build macro: SKEW_SHAPE_BYPASS_EN.

// One row of one bank: a DEPTH-deep shift line of (vld, data) stages.
module skew_shape_row #(
  parameter int W     = 8,
  parameter int DEPTH = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         adv,
  input  logic         bypass,
  input  logic         in_vld,
  input  logic [W-1:0] in_data,
  output logic         out_vld,
  output logic [W-1:0] out_data,
  output logic         post_vld   // any stage valid after this cycle's shift
);
  logic [DEPTH-1:0]        vld_q;
  logic [DEPTH-1:0][W-1:0] dat_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      dat_q <= '0;
    end else if (adv) begin
      // bubbles carry zero data so idle rows always present 0
      vld_q[0] <= in_vld;
      dat_q[0] <= in_vld ? in_data : '0;
      for (int k = 1; k < DEPTH; k++) begin
        vld_q[k] <= bypass ? 1'b0 : vld_q[k-1];
        dat_q[k] <= bypass ? '0   : dat_q[k-1];
      end
    end
  end

  assign out_vld  = bypass ? vld_q[0] : vld_q[DEPTH-1];
  assign out_data = bypass ? dat_q[0] : dat_q[DEPTH-1];

  // After a shift, stage 0 holds in_vld and stage k holds old stage k-1.
  always_comb begin
    post_vld = in_vld;
    if (!bypass)
      for (int k = 0; k < DEPTH-1; k++) post_vld = post_vld | vld_q[k];
  end
endmodule

module skew_shape_tx #(
  parameter int ACT_WIDTH = 8,
  parameter int NUM_BANK  = 4,
  parameter int NUM_ROW   = 16
) (
  input  logic clk,
  input  logic rst_n,
`ifdef SKEW_SHAPE_BYPASS_EN
  input  logic cfg_bypass,
`endif
  skew_shape_tx_if.slave bus
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  logic [NUM_BANK-1:0]                   in_rdy, busy_w, done_q;
  logic [NUM_BANK*NUM_ROW-1:0]           out_vld;
  logic [NUM_BANK*NUM_ROW*ACT_WIDTH-1:0] out_dat;

  for (genvar b = 0; b < NUM_BANK; b++) begin : g_bank
    logic [NUM_ROW-1:0] rvld, rrdy, post;
    logic               adv, acc, bypass_q;
    logic [1:0]         state;

    assign rvld = out_vld[b*NUM_ROW +: NUM_ROW];
    assign rrdy = bus.out_data_rdy[b*NUM_ROW +: NUM_ROW];
    // Whole bank moves only if no valid row is stalled.
    assign adv  = &(~rvld | rrdy);
    // rst_n gate keeps rdy low while reset is asserted.
    assign in_rdy[b] = rst_n & adv & (state != DRAIN);
    assign acc       = bus.in_data_vld[b] & in_rdy[b];

    for (genvar j = 0; j < NUM_ROW; j++) begin : g_row
      skew_shape_row #(.W(ACT_WIDTH), .DEPTH(j+1)) u_row (
        .clk      (clk),
        .rst_n    (rst_n),
        .adv      (adv),
        .bypass   (bypass_q),
        .in_vld   (acc),
        .in_data  (bus.in_data[(b*NUM_ROW+j)*ACT_WIDTH +: ACT_WIDTH]),
        .out_vld  (out_vld[b*NUM_ROW+j]),
        .out_data (out_dat[(b*NUM_ROW+j)*ACT_WIDTH +: ACT_WIDTH]),
        .post_vld (post[j])
      );
    end

`ifdef SKEW_SHAPE_BYPASS_EN
    // Mode is latched once per tile; later cfg_bypass changes are ignored.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                  bypass_q <= 1'b0;
      else if (state == IDLE && acc) bypass_q <= cfg_bypass;
    end
`else
    assign bypass_q = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state     <= IDLE;
        done_q[b] <= 1'b0;
      end else begin
        done_q[b] <= 1'b0;
        case (state)
          IDLE:    if (acc) state <= bus.in_data_last[b] ? DRAIN : RUN;
          RUN:     if (acc && bus.in_data_last[b]) state <= DRAIN;
          DRAIN:   if (adv && !(|post)) begin
                     state     <= IDLE;
                     done_q[b] <= 1'b1;
                   end
          default: state <= IDLE;
        endcase
      end
    end

    assign busy_w[b] = (state != IDLE);
  end

  assign bus.in_data_rdy  = in_rdy;
  assign bus.out_data_vld = out_vld;
  assign bus.out_data     = out_dat;
  assign bus.busy         = busy_w;
  assign bus.done         = done_q;
endmodule
